// File: rtl/coder_if.sv
// Stream bundle for the LCPLC block entropy coder.
// Holds the five input streams (ehat, kj, d_flag, alpha, xmean), the packed output stream,
// the flush request/ack pair and a debug view of the coder FSM state.
// Every stream is valid/ready: a beat moves on a rising edge where valid && ready are both high.
// A producer keeps valid and data steady until that beat.
// The slave modport is the coder's view; the master modport is the view of whatever drives the coder.
interface coder_if #(
   parameter int MAPPED_ERROR_WIDTH = 19,
   parameter int ACC_LOG            = 5,
   parameter int OUTPUT_WIDTH_LOG   = 5,
   parameter int ALPHA_WIDTH        = 10,
   parameter int DATA_WIDTH         = 16
) ();
   localparam int W = 1 << OUTPUT_WIDTH_LOG;

   logic                          flush;
   logic                          flushed;
   logic [MAPPED_ERROR_WIDTH-1:0] ehat_data;
   logic                          ehat_valid;
   logic                          ehat_ready;
   logic [ACC_LOG-1:0]            kj_data;
   logic                          kj_valid;
   logic                          kj_ready;
   logic                          d_flag_data;
   logic                          d_flag_valid;
   logic                          d_flag_ready;
   logic [ALPHA_WIDTH-1:0]        alpha_data;
   logic                          alpha_valid;
   logic                          alpha_ready;
   logic [DATA_WIDTH-1:0]         xmean_data;
   logic                          xmean_valid;
   logic                          xmean_ready;
   logic [W-1:0]                  output_data;
   logic                          output_valid;
   logic                          output_ready;
   logic [1:0]                    state_dbg;

   modport slave (
      input  flush, ehat_data, ehat_valid, kj_data, kj_valid, d_flag_data, d_flag_valid,
             alpha_data, alpha_valid, xmean_data, xmean_valid, output_ready,
      output flushed, ehat_ready, kj_ready, d_flag_ready, alpha_ready, xmean_ready,
             output_data, output_valid, state_dbg
   );

   modport master (
      output flush, ehat_data, ehat_valid, kj_data, kj_valid, d_flag_data, d_flag_valid,
             alpha_data, alpha_valid, xmean_data, xmean_valid, output_ready,
      input  flushed, ehat_ready, kj_ready, d_flag_ready, alpha_ready, xmean_ready,
             output_data, output_valid, state_dbg
   );
endinterface

// File: rtl/coder.sv
// LCPLC block entropy coder.
// For each block it emits a header (alpha, xmean, d_flag), then an exp-Golomb-0 code for the first
// error, then Golomb-Rice codes (parameter kj) for the remaining N-1 errors.
// The bits are packed MSB-first into W-bit words.
// Bits are kept left-aligned in a 2*W+64 bit buffer: the oldest bit sits in the MSB, and every bit
// below the fill level is zero. That zero tail is what makes the flush padding come for free.
// Optional macro CODER_ASSERTIONS_EN adds simulation-only protocol checks.
// The state encoding is visible on bus.state_dbg: 0 HEADER, 1 FIRST, 2 REST, 3 FLUSH.
module coder #(
   parameter int MAPPED_ERROR_WIDTH = 19,
   parameter int ACC_LOG            = 5,
   parameter int BLOCK_SIZE_LOG     = 8,
   parameter int OUTPUT_WIDTH_LOG   = 5,
   parameter int ALPHA_WIDTH        = 10,
   parameter int DATA_WIDTH         = 16
) (
   input logic  clk,
   input logic  rst,
   coder_if.slave bus
);
   localparam int W        = 1 << OUTPUT_WIDTH_LOG;
   localparam int N        = 1 << BLOCK_SIZE_LOG;
   localparam int HDR_LEN  = ALPHA_WIDTH + DATA_WIDTH + 1;
   localparam int ESC      = 32;
   localparam int CODE_W   = 64;          // longest code, even for out-of-range kj
   localparam int BUF_W    = 2 * W + 64;
   localparam int FILL_W   = $clog2(BUF_W + 1);
   localparam int LEN_W    = $clog2(CODE_W + 1);
   localparam int MSB_W    = $clog2(MAPPED_ERROR_WIDTH + 1);

   typedef enum logic [1:0] {
      HEADER = 2'd0,
      FIRST  = 2'd1,
      REST   = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   state_t                    state;
   logic [BLOCK_SIZE_LOG-1:0] count;
   logic                      skip;
   logic                      flushed_r;
   logic [BUF_W-1:0]          buf_q;
   logic [FILL_W-1:0]         fill;

   logic                      room;
   logic                      hdr_fire;
   logic                      first_ready;
   logic                      first_fire;
   logic                      rest_fire;
   logic                      pop;
   logic                      out_valid;

   logic [CODE_W-1:0]             code_val;
   logic [LEN_W-1:0]              code_len;
   logic                          append;
   logic [MAPPED_ERROR_WIDTH:0]   v1;
   logic [MSB_W-1:0]              msb;
   logic [MAPPED_ERROR_WIDTH-1:0] q;
   logic [MAPPED_ERROR_WIDTH-1:0] mask;

   logic [BUF_W-1:0]  buf_p;
   logic [BUF_W-1:0]  buf_n;
   logic [FILL_W-1:0] fill_p;
   logic [FILL_W-1:0] fill_n;
   logic [FILL_W-1:0] shamt;

   // Input acceptance: an input is only accepted when a worst-case code still fits; the buffer fill
   // before this cycle's pop is used, so ready never depends on output_ready.
   assign room        = fill <= FILL_W'(BUF_W - CODE_W);
   assign hdr_fire    = !rst && state == HEADER && !bus.flush && bus.alpha_valid &&
                        bus.xmean_valid && bus.d_flag_valid && room;
   assign first_ready = !rst && state == FIRST && room;
   assign first_fire  = first_ready && bus.ehat_valid;
   assign rest_fire   = !rst && state == REST && bus.ehat_valid && bus.kj_valid && room;

   assign bus.alpha_ready  = hdr_fire;
   assign bus.xmean_ready  = hdr_fire;
   assign bus.d_flag_ready = hdr_fire;
   assign bus.ehat_ready   = first_ready || rest_fire;
   assign bus.kj_ready     = rest_fire;

   assign out_valid        = fill >= FILL_W'(W);
   assign pop              = out_valid && bus.output_ready;
   assign bus.output_valid = out_valid;
   assign bus.output_data  = buf_q[BUF_W-1 -: W];
   assign bus.flushed      = flushed_r;
   assign bus.state_dbg    = state;

   // Code builder: right-aligned code value plus its length. Leading zeros are implied by the length.
   always_comb begin
      code_val = '0;
      code_len = '0;
      append   = 1'b0;
      msb      = '0;
      v1       = {1'b0, bus.ehat_data} + 1'b1;
      q        = bus.ehat_data >> bus.kj_data;
      mask     = (MAPPED_ERROR_WIDTH'(1) << bus.kj_data) - MAPPED_ERROR_WIDTH'(1);
      for (int i = 0; i <= MAPPED_ERROR_WIDTH; i++) begin
         if (v1[i]) msb = MSB_W'(i);
      end
      if (hdr_fire) begin
         code_val = CODE_W'({bus.alpha_data, bus.xmean_data, bus.d_flag_data});
         code_len = LEN_W'(HDR_LEN);
         append   = 1'b1;
      end else if (first_fire && !skip) begin
         // EG0: msb zeros followed by the (msb+1)-bit value of v+1
         code_val = CODE_W'(v1);
         code_len = LEN_W'({msb, 1'b1});
         append   = 1'b1;
      end else if (rest_fire && !skip) begin
         if (q < MAPPED_ERROR_WIDTH'(ESC)) begin
            code_val = (CODE_W'(1) << bus.kj_data) | CODE_W'(bus.ehat_data & mask);
            code_len = LEN_W'(q[4:0]) + LEN_W'(1) + LEN_W'(bus.kj_data);
         end else begin
            code_val = CODE_W'(bus.ehat_data);
            code_len = LEN_W'(ESC + MAPPED_ERROR_WIDTH);
         end
         append = 1'b1;
      end
   end

   // Next buffer contents: drop the word leaving this cycle, then splice the new code in below the
   // remaining bits.
   always_comb begin
      buf_p  = buf_q;
      fill_p = fill;
      shamt  = '0;
      if (pop) begin
         buf_p  = buf_q << W;
         fill_p = fill - FILL_W'(W);
      end
      buf_n  = buf_p;
      fill_n = fill_p;
      if (append) begin
         shamt  = FILL_W'(BUF_W) - fill_p - FILL_W'(code_len);
         buf_n  = buf_p | ({{(BUF_W - CODE_W){1'b0}}, code_val} << shamt);
         fill_n = fill_p + FILL_W'(code_len);
      end
   end

   // Block sequencing FSM, together with the bit buffer and the flush handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HEADER;
         count     <= '0;
         skip      <= 1'b0;
         flushed_r <= 1'b0;
         buf_q     <= '0;
         fill      <= '0;
      end else begin
         buf_q     <= buf_n;
         fill      <= fill_n;
         flushed_r <= 1'b0;
         case (state)
            HEADER: begin
               if (bus.flush) begin
                  if (fill == '0 || (pop && fill == FILL_W'(W))) flushed_r <= 1'b1;
                  else                                          state     <= FLUSH;
               end else if (hdr_fire) begin
                  skip  <= bus.d_flag_data;
                  state <= FIRST;
               end
            end
            FIRST: begin
               if (first_fire) begin
                  count <= '0;
                  state <= REST;
               end
            end
            REST: begin
               if (rest_fire) begin
                  if (count == BLOCK_SIZE_LOG'(N - 2)) begin
                     count <= '0;
                     state <= HEADER;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            FLUSH: begin
               // A partial tail is already zero-padded below the fill level, so padding is only a
               // bump of the fill count up to one full word.
               if (fill < FILL_W'(W)) begin
                  if (fill != '0) fill <= FILL_W'(W);
               end else if (pop && fill == FILL_W'(W)) begin
                  flushed_r <= 1'b1;
                  state     <= HEADER;
               end
            end
            default: state <= HEADER;
         endcase
      end
   end

`ifdef CODER_ASSERTIONS_EN
   logic         chk_stall;
   logic [W-1:0] chk_data;

   // Simulation-only protocol checks on the output hold and the input value ranges.
   always_ff @(posedge clk) begin
      chk_stall <= !rst && out_valid && !bus.output_ready;
      chk_data  <= bus.output_data;
      if (!rst) begin
         if (chk_stall && bus.output_data != chk_data)
            $error("coder: output_data changed while stalled");
         if (rest_fire && int'(bus.kj_data) > MAPPED_ERROR_WIDTH)
            $error("coder: kj_data %0d out of range", bus.kj_data);
         if (first_fire && int'(bus.ehat_data) >= (1 << MAPPED_ERROR_WIDTH) - 1)
            $error("coder: first ehat %0h out of range", bus.ehat_data);
      end
   end
`endif
endmodule

// File: tb/tb_coder.sv
// Bench for the LCPLC block entropy coder.
// The reference model builds the expected bitstream bit by bit from the code rules (header, EG0,
// Rice with escape), then cuts it into 32-bit words.
module tb_coder;
   localparam int MEW = 19;
   localparam int ACC = 5;
   localparam int BSL = 8;
   localparam int OWL = 5;
   localparam int AW  = 10;
   localparam int DW  = 16;
   localparam int W   = 1 << OWL;
   localparam int N   = 1 << BSL;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   coder_if #(.MAPPED_ERROR_WIDTH(MEW), .ACC_LOG(ACC), .OUTPUT_WIDTH_LOG(OWL),
              .ALPHA_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   coder #(.MAPPED_ERROR_WIDTH(MEW), .ACC_LOG(ACC), .BLOCK_SIZE_LOG(BSL),
           .OUTPUT_WIDTH_LOG(OWL), .ALPHA_WIDTH(AW), .DATA_WIDTH(DW))
      dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   int flushed_cnt = 0;
   bit stall_mode = 1'b0;

   logic [W-1:0]     exp_q[$];
   logic [W-1:0]     got_q[$];
   bit               bit_q[$];
   logic [AW+DW:0]   hdr_q[$];
   logic [MEW-1:0]   ehat_q[$];
   logic [ACC-1:0]   kj_q[$];
   logic [MEW-1:0]   blk_e[N];
   logic [ACC-1:0]   blk_k[N];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic push_bits(input logic [63:0] v, input int len);
      for (int i = len - 1; i >= 0; i--) bit_q.push_back(v[i]);
   endtask

   task automatic push_zeros(input int len);
      for (int i = 0; i < len; i++) bit_q.push_back(1'b0);
   endtask

   task automatic pack_words(input bit pad);
      logic [W-1:0] w;
      if (pad && bit_q.size() > 0)
         while (bit_q.size() % W != 0) bit_q.push_back(1'b0);
      while (bit_q.size() >= W) begin
         w = '0;
         for (int i = 0; i < W; i++) w = {w[W-2:0], bit_q.pop_front()};
         exp_q.push_back(w);
      end
   endtask

   // Queue one block for the drivers and append its expected bits.
   task automatic add_block(input logic [AW-1:0] a, input logic [DW-1:0] x, input bit d);
      int unsigned v, n, e, k, qq;
      hdr_q.push_back({a, x, d});
      push_bits(64'({a, x, d}), AW + DW + 1);
      for (int i = 0; i < N; i++) ehat_q.push_back(blk_e[i]);
      for (int i = 1; i < N; i++) kj_q.push_back(blk_k[i]);
      if (!d) begin
         v = int'(blk_e[0]) + 1;
         n = 0;
         while ((v >> (n + 1)) != 0) n++;
         push_zeros(n);
         push_bits(64'(v), n + 1);
         for (int i = 1; i < N; i++) begin
            e  = blk_e[i];
            k  = blk_k[i];
            qq = e >> k;
            if (qq < 32) begin
               push_zeros(qq);
               bit_q.push_back(1'b1);
               push_bits(64'(e), k);
            end else begin
               push_zeros(32);
               push_bits(64'(e), MEW);
            end
         end
      end
      pack_words(1'b0);
   endtask

   function automatic logic [MEW-1:0] rnd_e();
      case ($urandom_range(0, 9))
         0:       return MEW'($urandom_range(0, (1 << MEW) - 1));
         1, 2:    return MEW'($urandom_range(0, 255));
         default: return MEW'($urandom_range(0, 15));
      endcase
   endfunction

   function automatic logic [ACC-1:0] rnd_k();
      if ($urandom_range(0, 9) == 0) return ACC'($urandom_range(0, MEW));
      return ACC'($urandom_range(0, 4));
   endfunction

   task automatic fill_blk();
      for (int i = 0; i < N; i++) begin
         blk_e[i] = rnd_e();
         blk_k[i] = rnd_k();
      end
      blk_e[0] = ($urandom_range(0, 3) == 0) ? MEW'($urandom_range(0, (1 << MEW) - 2))
                                              : MEW'($urandom_range(0, 63));
   endtask

   // ---------------- drivers ----------------
   initial begin : drv_hdr
      bit fire;
      bus.alpha_valid = 1'b0; bus.xmean_valid = 1'b0; bus.d_flag_valid = 1'b0;
      bus.alpha_data = '0; bus.xmean_data = '0; bus.d_flag_data = 1'b0;
      forever begin
         @(negedge clk);
         fire = bus.alpha_valid && bus.alpha_ready;
         @(posedge clk);
         #1;
         if (rst) begin
            bus.alpha_valid = 1'b0; bus.xmean_valid = 1'b0; bus.d_flag_valid = 1'b0;
         end else begin
            if (fire && hdr_q.size() > 0) begin
               void'(hdr_q.pop_front());
               bus.alpha_valid = 1'b0; bus.xmean_valid = 1'b0; bus.d_flag_valid = 1'b0;
            end
            if (!bus.alpha_valid && hdr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               {bus.alpha_data, bus.xmean_data, bus.d_flag_data} = hdr_q[0];
               bus.alpha_valid = 1'b1; bus.xmean_valid = 1'b1; bus.d_flag_valid = 1'b1;
            end
         end
      end
   end

   initial begin : drv_ehat
      bit fire;
      bus.ehat_valid = 1'b0;
      bus.ehat_data  = '0;
      forever begin
         @(negedge clk);
         fire = bus.ehat_valid && bus.ehat_ready;
         @(posedge clk);
         #1;
         if (rst) bus.ehat_valid = 1'b0;
         else begin
            if (fire && ehat_q.size() > 0) begin
               void'(ehat_q.pop_front());
               bus.ehat_valid = 1'b0;
            end
            if (!bus.ehat_valid && ehat_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               bus.ehat_data  = ehat_q[0];
               bus.ehat_valid = 1'b1;
            end
         end
      end
   end

   initial begin : drv_kj
      bit fire;
      bus.kj_valid = 1'b0;
      bus.kj_data  = '0;
      forever begin
         @(negedge clk);
         fire = bus.kj_valid && bus.kj_ready;
         @(posedge clk);
         #1;
         if (rst) bus.kj_valid = 1'b0;
         else begin
            if (fire && kj_q.size() > 0) begin
               void'(kj_q.pop_front());
               bus.kj_valid = 1'b0;
            end
            if (!bus.kj_valid && kj_q.size() > 0 && $urandom_range(0, 3) != 0) begin
               bus.kj_data  = kj_q[0];
               bus.kj_valid = 1'b1;
            end
         end
      end
   end

   initial begin : drv_ready
      bus.output_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.output_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   // ---------------- output monitor ----------------
   initial begin : mon
      bit           prev_stall;
      logic [W-1:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) prev_stall = 1'b0;
         else begin
            if (prev_stall) begin
               check("stall_valid_hold", 64'(bus.output_valid), 64'd1);
               check("stall_data_hold", 64'(bus.output_data), 64'(prev_data));
            end
            if (bus.output_valid && bus.output_ready) got_q.push_back(bus.output_data);
            if (bus.flushed) flushed_cnt++;
            prev_stall = bus.output_valid && !bus.output_ready;
            prev_data  = bus.output_data;
         end
      end
   end

   // ---------------- sequence helpers ----------------
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.flush = 1'b0;
      hdr_q.delete(); ehat_q.delete(); kj_q.delete();
      bit_q.delete(); exp_q.delete(); got_q.delete();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while ((hdr_q.size() + ehat_q.size() + kj_q.size()) != 0 && c < 20000) begin
         @(posedge clk);
         c++;
      end
      check(tag, 64'(c < 20000), 64'd1);
      repeat (2) @(posedge clk);
   endtask

   task automatic do_flush(input string tag);
      int start;
      int c = 0;
      start = flushed_cnt;
      @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      while (flushed_cnt == start && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_flush_done"}, 64'(c < 2000), 64'd1);
      repeat (4) @(negedge clk);
      check({tag, "_flushed_pulses"}, 64'(flushed_cnt - start), 64'd1);
      pack_words(1'b1);
   endtask

   task automatic compare_words(input string tag);
      int n;
      check({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      bus.flush = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("rst_alpha_ready", 64'(bus.alpha_ready), 64'd0);
      check("rst_ehat_ready", 64'(bus.ehat_ready), 64'd0);
      check("rst_kj_ready", 64'(bus.kj_ready), 64'd0);
      check("rst_output_valid", 64'(bus.output_valid), 64'd0);
      check("rst_flushed", 64'(bus.flushed), 64'd0);

      // Block 1: EG0 of 0 and Rice codes of 0, then an escape (200, kj=0) and 9 with kj=2.
      fill_blk();
      for (int i = 0; i < 5; i++) begin
         blk_e[i] = '0;
         blk_k[i] = '0;
      end
      blk_e[5] = MEW'(200); blk_k[5] = ACC'(0);
      blk_e[6] = MEW'(9);   blk_k[6] = ACC'(2);
      add_block(AW'(10'h155), DW'(16'h1234), 1'b0);
      // Block 2 opens with ehat=3; block 3 is skipped; block 4 is random.
      fill_blk();
      blk_e[0] = MEW'(3);
      add_block(AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 65535)), 1'b0);
      fill_blk();
      add_block(AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 65535)), 1'b1);
      fill_blk();
      add_block(AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 65535)), 1'b0);
      wait_idle("p1_idle");
      check("p1_first_word", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hdead, 64'h55448D1F);
      do_flush("p1");
      compare_words("p1");

      // Reset in the middle of a block; afterwards a skipped block leaves 27 bits for the flush.
      fill_blk();
      add_block(AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 65535)), 1'b0);
      repeat (60) @(posedge clk);
      do_reset();
      fill_blk();
      add_block(AW'(10'h2AA), DW'(16'hBEEF), 1'b1);
      wait_idle("p2_idle");
      check("p2_words_before_flush", 64'(got_q.size()), 64'd0);
      do_flush("p2");
      check("p2_flush_word_count", 64'(got_q.size()), 64'd1);
      check("p2_flush_word", (got_q.size() > 0) ? 64'(got_q[0]) : 64'hdead,
            64'({10'h2AA, 16'hBEEF, 1'b1, 5'b00000}));
      compare_words("p2");

      // Flush with an empty buffer: flushed one cycle later, no word.
      @(posedge clk);
      #1 bus.flush = 1'b1;
      @(negedge clk);
      check("p3_flushed_early", 64'(bus.flushed), 64'd0);
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("p3_flushed_pulse", 64'(bus.flushed), 64'd1);
      @(negedge clk);
      check("p3_flushed_drop", 64'(bus.flushed), 64'd0);
      check("p3_no_word", 64'(got_q.size()), 64'd0);

      // Four random blocks under random output backpressure.
      stall_mode = 1'b1;
      for (int b = 0; b < 4; b++) begin
         fill_blk();
         add_block(AW'($urandom_range(0, 1023)), DW'($urandom_range(0, 65535)), b == 2);
      end
      wait_idle("p4_idle");
      do_flush("p4");
      compare_words("p4");
      stall_mode = 1'b0;

      repeat (5) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
